// File: rtl/uart_rx_os.sv
// UART receiver with 16x oversampling, 3-sample majority vote, runtime frame
// format, break detection and a small first-word-fall-through output FIFO.
`timescale 1ns/1ps
module uart_rx_os #(
  parameter int MAX_DATA_BITS = 9,
  parameter int OVERSAMPLE    = 16,
  parameter int DIV_WIDTH     = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  input  logic [DIV_WIDTH-1:0]     cfg_div,
  input  logic [3:0]               cfg_data_bits,
  input  logic [1:0]               cfg_parity,
  input  logic                     cfg_stop2,
  output logic [MAX_DATA_BITS-1:0] m_data,
  output logic                     m_parity_err,
  output logic                     m_frame_err,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     break_det,
  output logic                     overrun,
  output logic                     busy
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int EW   = MAX_DATA_BITS + 2;
  localparam logic [OS_W-1:0] OS_S0   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_S1   = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0] OS_S2   = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [AW:0]     DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

  state_t                   state_reg, state_next;
  logic                     sync1_reg, sync2_reg, prev_reg;
  logic [DIV_WIDTH-1:0]     div_reg;
  logic [OS_W-1:0]          os_reg;
  logic                     s0_reg, s1_reg;
  logic [3:0]               nbits_reg;
  logic [1:0]               par_cfg_reg;
  logic                     stop2_reg;
  logic [MAX_DATA_BITS-1:0] data_reg;
  logic [3:0]               bit_cnt_reg;
  logic                     par_bit_reg, par_err_reg, frame_err_reg, stop_idx_reg;
  logic                     push_reg, brk_reg, ovr_reg;
  logic [AW-1:0]            wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]              count_reg;
  logic [EW-1:0]            mem [FIFO_DEPTH];

  logic start_edge, tick, dec, wrap, maj, par_en, par_exp, is_break;
  logic brk_now, stop_final, full, pop, wr_en;
  logic [EW-1:0] head;

  assign start_edge = (state_reg == IDLE) && prev_reg && !sync2_reg;
  assign tick       = (div_reg == cfg_div);
  assign dec        = tick && (os_reg == OS_S2);
  assign wrap       = tick && (os_reg == OS_LAST);
  assign maj        = (s0_reg & s1_reg) | (s0_reg & sync2_reg) | (s1_reg & sync2_reg);
  assign par_en     = par_cfg_reg[0] ^ par_cfg_reg[1];
  assign par_exp    = par_cfg_reg[1] ? ~^data_reg : ^data_reg;
  assign is_break   = (data_reg == '0) && (!par_en || !par_bit_reg) && !maj;
  assign brk_now    = dec && (state_reg == STOP) && !stop_idx_reg && is_break;
  assign stop_final = dec && (state_reg == STOP) && (stop_idx_reg || !stop2_reg || is_break);

  assign full  = (count_reg == DEPTH_C);
  assign pop   = m_valid && m_ready;
  assign wr_en = push_reg && (!full || pop);
  assign head  = mem[rd_ptr_reg];

  assign m_valid = (count_reg != '0);
  assign busy    = (state_reg != IDLE);
  assign break_det = brk_reg;
  assign overrun   = ovr_reg;

  // Head entry is masked to zero while the FIFO is empty so outputs read 0 after reset.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_DATA_BITS; gi++) begin : g_mask
      assign m_data[gi] = m_valid & head[gi];
    end
  endgenerate
  assign m_parity_err = m_valid & head[MAX_DATA_BITS];
  assign m_frame_err  = m_valid & head[MAX_DATA_BITS+1];

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; bit transitions happen on the oversample wrap, stop ends early.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (start_edge) state_next = START;
      START: begin
        if (dec && maj)  state_next = IDLE;
        else if (wrap)   state_next = DATA;
      end
      DATA:     if (wrap && (bit_cnt_reg >= nbits_reg)) state_next = par_en ? PARITY : STOP;
      PARITY:   if (wrap) state_next = STOP;
      STOP: begin
        if (brk_now)         state_next = BRK_WAIT;
        else if (stop_final) state_next = IDLE;
      end
      BRK_WAIT: if (sync2_reg) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Synchroniser, tick generation, sampling and frame datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg     <= 1'b1;
      sync2_reg     <= 1'b1;
      prev_reg      <= 1'b1;
      div_reg       <= '0;
      os_reg        <= '0;
      s0_reg        <= 1'b1;
      s1_reg        <= 1'b1;
      nbits_reg     <= 4'd8;
      par_cfg_reg   <= 2'b00;
      stop2_reg     <= 1'b0;
      data_reg      <= '0;
      bit_cnt_reg   <= '0;
      par_bit_reg   <= 1'b0;
      par_err_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
      stop_idx_reg  <= 1'b0;
      push_reg      <= 1'b0;
      brk_reg       <= 1'b0;
      ovr_reg       <= 1'b0;
    end else begin
      sync1_reg <= rx;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      push_reg  <= stop_final;
      brk_reg   <= brk_now;
      ovr_reg   <= push_reg && full && !pop;

      if (start_edge || tick) div_reg <= '0;
      else                    div_reg <= div_reg + 1'b1;

      if (start_edge)  os_reg <= '0;
      else if (tick)   os_reg <= (os_reg == OS_LAST) ? '0 : os_reg + 1'b1;

      if (tick && (os_reg == OS_S0)) s0_reg <= sync2_reg;
      if (tick && (os_reg == OS_S1)) s1_reg <= sync2_reg;

      if (start_edge) begin
        nbits_reg     <= cfg_data_bits;
        par_cfg_reg   <= cfg_parity;
        stop2_reg     <= cfg_stop2;
        data_reg      <= '0;
        bit_cnt_reg   <= '0;
        par_bit_reg   <= 1'b0;
        par_err_reg   <= 1'b0;
        frame_err_reg <= 1'b0;
        stop_idx_reg  <= 1'b0;
      end else if (dec) begin
        case (state_reg)
          DATA: begin
            if (bit_cnt_reg < nbits_reg) begin
              data_reg    <= data_reg | ({{(MAX_DATA_BITS-1){1'b0}}, maj} << bit_cnt_reg);
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end
          PARITY: begin
            par_bit_reg <= maj;
            par_err_reg <= (maj != par_exp);
          end
          STOP: begin
            if (!maj) frame_err_reg <= 1'b1;
            stop_idx_reg <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= {frame_err_reg, par_err_reg, data_reg};
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: frame formats, errors, break, FIFO overrun,
// glitch rejection and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_rx_os;

  logic        clk = 1'b0;
  logic        rst, rx, cfg_stop2, m_ready;
  logic [15:0] cfg_div;
  logic [3:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic [8:0]  m_data;
  logic        m_parity_err, m_frame_err, m_valid, break_det, overrun, busy;

  int vectors = 0;
  int miscompares = 0;
  int brk_cnt = 0;
  int ovr_cnt = 0;
  int bit_clks = 64;
  int brk_base, ovr_base;

  uart_rx_os #(.MAX_DATA_BITS(9), .OVERSAMPLE(16), .DIV_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rx(rx), .cfg_div(cfg_div), .cfg_data_bits(cfg_data_bits),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .m_data(m_data),
    .m_parity_err(m_parity_err), .m_frame_err(m_frame_err), .m_valid(m_valid),
    .m_ready(m_ready), .break_det(break_det), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // Count one-cycle pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (break_det) brk_cnt++;
    if (overrun)   ovr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // pmode: 0 none, 1 even, 2 odd; pflip inverts the parity bit sent.
  task automatic send_frame(input logic [8:0] d, input int nb, input int pmode,
                            input logic pflip, input logic stop_val, input int nstop);
    logic p;
    rx = 1'b0; idle(bit_clks);
    for (int i = 0; i < nb; i++) begin rx = d[i]; idle(bit_clks); end
    if (pmode != 0) begin
      p = 1'b0;
      for (int i = 0; i < nb; i++) p = p ^ d[i];
      if (pmode == 2) p = ~p;
      rx = p ^ pflip; idle(bit_clks);
    end
    for (int i = 0; i < nstop; i++) begin
      rx = (i == 0) ? stop_val : 1'b1; idle(bit_clks);
    end
    rx = 1'b1; idle(2 * bit_clks);
  endtask

  task automatic expect_entry(input string tag, input logic [31:0] d, input logic [31:0] pe,
                              input logic [31:0] fe);
    int n;
    n = 0;
    while (!m_valid && n < 3000) begin idle(1); n++; end
    check({tag, " valid"}, 32'(m_valid), 1);
    check({tag, " data"},  32'(m_data), d);
    check({tag, " perr"},  32'(m_parity_err), pe);
    check({tag, " ferr"},  32'(m_frame_err), fe);
    $display("entry %s: data=0x%03h perr=%0b ferr=%0b", tag, m_data, m_parity_err, m_frame_err);
    m_ready = 1'b1; idle(1); m_ready = 1'b0;
  endtask

  task automatic set_cfg(input logic [15:0] div, input logic [3:0] nb, input logic [1:0] par,
                         input logic s2);
    cfg_div = div; cfg_data_bits = nb; cfg_parity = par; cfg_stop2 = s2;
    bit_clks = (int'(div) + 1) * 16;
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; m_ready = 1'b0;
    set_cfg(16'd3, 4'd8, 2'b00, 1'b0);
    idle(4);
    check("rst m_valid", 32'(m_valid), 0);
    check("rst m_data", 32'(m_data), 0);
    check("rst perr", 32'(m_parity_err), 0);
    check("rst ferr", 32'(m_frame_err), 0);
    check("rst break", 32'(break_det), 0);
    check("rst overrun", 32'(overrun), 0);
    check("rst busy", 32'(busy), 0);
    rst = 1'b0; idle(4);

    // 8N1 0xA5
    send_frame(9'h0A5, 8, 0, 1'b0, 1'b1, 1);
    expect_entry("8N1 a5", 'h0A5, 0, 0);
    check("a5 single entry", 32'(m_valid), 0);

    // 7E2 0x55 with wrong parity
    set_cfg(16'd3, 4'd7, 2'b01, 1'b1);
    send_frame(9'h055, 7, 1, 1'b1, 1'b1, 2);
    expect_entry("7E2 55 badpar", 'h055, 1, 0);

    // 9O1 0x1FF correct parity
    set_cfg(16'd3, 4'd9, 2'b10, 1'b0);
    send_frame(9'h1FF, 9, 2, 1'b0, 1'b1, 1);
    expect_entry("9O1 1ff", 'h1FF, 0, 0);

    // 5N1 0x1F
    set_cfg(16'd3, 4'd5, 2'b00, 1'b0);
    send_frame(9'h01F, 5, 0, 1'b0, 1'b1, 1);
    expect_entry("5N1 1f", 'h01F, 0, 0);

    // 8N1 0x3C with low stop bit
    set_cfg(16'd3, 4'd8, 2'b00, 1'b0);
    send_frame(9'h03C, 8, 0, 1'b0, 1'b0, 1);
    expect_entry("8N1 3c lowstop", 'h03C, 0, 1);

    // Break: rx low for three frame times
    brk_base = brk_cnt;
    rx = 1'b0; idle(3 * 10 * bit_clks);
    check("brk valid", 32'(m_valid), 1);
    check("brk pulses", 32'(brk_cnt - brk_base), 1);
    check("brk busy waiting", 32'(busy), 1);
    expect_entry("break", 'h000, 0, 1);
    idle(bit_clks);
    check("brk no extra entry", 32'(m_valid), 0);
    rx = 1'b1; idle(10);
    check("brk busy released", 32'(busy), 0);
    check("brk still one pulse", 32'(brk_cnt - brk_base), 1);
    idle(2 * bit_clks);

    // FIFO overrun at cfg_div=0 with consumer stalled
    set_cfg(16'd0, 4'd8, 2'b00, 1'b0);
    ovr_base = ovr_cnt;
    for (int k = 1; k <= 5; k++) send_frame(9'(k), 8, 0, 1'b0, 1'b1, 1);
    check("ovr pulses", 32'(ovr_cnt - ovr_base), 1);
    check("ovr head held", 32'(m_data), 'h001);
    for (int k = 1; k <= 4; k++) expect_entry($sformatf("fifo %0d", k), 32'(k), 0, 0);
    check("fifo drained", 32'(m_valid), 0);

    // Short glitch on rx is rejected
    set_cfg(16'd3, 4'd8, 2'b00, 1'b0);
    rx = 1'b0; idle(8); rx = 1'b1; idle(3);
    check("glitch busy", 32'(busy), 1);
    idle(2 * bit_clks);
    check("glitch idle", 32'(busy), 0);
    check("glitch no entry", 32'(m_valid), 0);

    // Reset mid-DATA, then a clean 0x81 frame
    brk_base = brk_cnt; ovr_base = ovr_cnt;
    rx = 1'b0; idle(bit_clks);
    rx = 1'b1; idle(bit_clks);
    rx = 1'b0; idle(3 * bit_clks);
    rst = 1'b1; rx = 1'b1; idle(3);
    check("midrst busy", 32'(busy), 0);
    rst = 1'b0; idle(2 * bit_clks);
    check("midrst no entry", 32'(m_valid), 0);
    check("midrst idle", 32'(busy), 0);
    send_frame(9'h081, 8, 0, 1'b0, 1'b1, 1);
    expect_entry("8N1 81 after rst", 'h081, 0, 0);
    check("midrst no pulses", 32'((brk_cnt - brk_base) + (ovr_cnt - ovr_base)), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
